de_stage_sb: RTL
================

Name: de_stage_sb

Overview:
- Parametrised successor decode stage for the RV32I pipeline.
- Decodes the fetched instruction, reads an NREGS×DBITS register file, sign-extends immediates and produces a single DE pipeline latch.
- Replaces the stall-wire scheme with per-register pending-write counters (scoreboard), valid/ready handshakes on both sides, and a flush input.
- Sits between FE and AGEX. Takes write-back from WB.

Parameters:
- DBITS, 32, data/PC width
- NREGS, 32, architectural registers; REGNOBITS = clog2(NREGS)
- MAX_INFLIGHT, 3, max outstanding writes per register; counter width CW = clog2(MAX_INFLIGHT+1)
- INSTBITS, 32, instruction width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fe_valid  in  1  FE has an instruction
- fe_inst  in  INSTBITS  instruction word
- fe_pc  in  DBITS  instruction PC
- fe_ready  out  1  DE accepts FE instruction this cycle
- flush  in  1  AGEX redirect; kill DE latch and FE input
- de_valid  out  1  DE latch holds a live instruction
- de_op  out  IOPBITS  internal opcode enum
- de_pc  out  DBITS  PC
- de_imm  out  DBITS  sign-extended immediate
- de_rs1_val  out  DBITS  rs1 operand
- de_rs2_val  out  DBITS  rs2 operand
- de_rd  out  REGNOBITS  destination register
- de_wr_reg  out  1  instruction writes rd (rd≠0)
- agex_ready  in  1  AGEX consumes DE latch
- wb_wr  in  1  WB register write
- wb_regno  in  REGNOBITS  WB destination
- wb_val  in  DBITS  WB data

Behaviour:
- One clock domain; every state update on posedge clk. Reset is synchronous, active-high.
- Reset: all regs = 0, all counters = 0, DE latch = 0, de_valid = 0. fe_ready is combinational and evaluates to 1 when fe_inst has no hazard.
- Decode: combinational from fe_inst.
  - Opcode/funct3/funct7 map to an op enum.
  - Unknown encodings map to INVALID_I, which is issued as a no-write NOP.
  - Immediate types: I/S/B/U/J per the RV32I encodings.
  - rs1/rs2 are used only for the formats that read them. An unused source never causes a hazard.
- Hazard: a used source s≠0 is hazardous if cnt[s]≠0 OR (de_valid && de_wr_reg && de_rd==s).
  - Structural stall: the instruction writes rd and cnt[rd]==MAX_INFLIGHT.
- fe_ready = !hazard && !structural && (!de_valid || agex_ready) && !flush.
- Latch load: on fe_valid && fe_ready, the DE latch captures the decode outputs; latency is 1 cycle.
  - If the latch drains (agex_ready) but the FE instruction is stalled, load a bubble (de_valid=0).
  - If !agex_ready, hold the latch unchanged.
- Scoreboard:
  - cnt[de_rd] increments when de_valid && agex_ready && de_wr_reg (issue to AGEX).
  - cnt[wb_regno] decrements when wb_wr && wb_regno≠0.
  - Same-cycle increment and decrement of the same register leaves the count unchanged.
  - A decrement at 0 is an illegal condition and is flagged by a bench assertion; the RTL saturates at 0.
- RF write: regs[wb_regno] ← wb_val when wb_wr && wb_regno≠0. x0 always reads 0 and is never busy.
- Flush:
  - Next cycle de_valid=0; fe_ready=0 during the flush cycle.
  - The DE-latch instruction is never issued, so its scoreboard count is not incremented.
  - Counters of already-issued instructions are untouched (they are older and will write back).
- Reset mid-operation: overrides flush, handshakes and WB in the same cycle.

Optional Feature:
- Macro: DE_WB_BYPASS_EN.
- Defined: a source s with cnt[s]==1 and wb_wr && wb_regno==s in the current cycle, and no DE-latch match, is not a hazard. Its operand takes wb_val directly in the same cycle.
- Undefined: that case stalls one cycle; the operand is read from the RF in the next cycle.

Decomposition:
- Package de_pkg:
  - op enum (IOPBITS, *_I codes)
  - RV32 opcode/funct3/funct7 constants
  - format-type and immediate-type enums
  - immediate-extraction function
- Sub-module de_scoreboard (parameters NREGS, MAX_INFLIGHT):
  - holds the counters
  - inputs: inc/inc_reg, dec/dec_reg, query regs
  - outputs: busy and full flags per query

Test Plan:
- Reset, then `addi x1,x0,5` with agex_ready=1 and WB returning 3 cycles later → de_valid next cycle, de_imm=5, de_rd=1; cnt[1]=1 after issue and 0 after WB.
- `addi x1,x0,5` followed by `add x2,x1,x1` → fe_ready=0 until the WB of x1; then de_rs1_val=de_rs2_val=5. With DE_WB_BYPASS_EN the stall is one cycle shorter.
- agex_ready=0 for 4 cycles with a valid latch → latch and outputs stable, fe_ready=0; then agex_ready=1 → issue and next load.
- Four consecutive writers of x3 with no WB, MAX_INFLIGHT=3 → the fourth writer holds (fe_ready=0) until one WB to x3.
- flush while the latch holds a writer of x5 → de_valid=0 next cycle, cnt[5] stays 0, a later read of x5 does not stall.
- WB to x0 with wb_val=0xFFFFFFFF → x0 still reads 0; `sub x4,x0,x0` gives operands 0/0 with no stall.

Source files
------------

// File: rtl/de_pkg.sv
// Shared decode definitions for the scoreboarded RV32I decode stage:
// internal op codes, RV32 field constants, format/immediate types and immediate extraction.
package de_pkg;

  localparam int IOPBITS = 6;

  typedef enum logic [IOPBITS-1:0] {
    INVALID_I = 6'd0,
    ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLT_I, SLTU_I, SLL_I, SRL_I, SRA_I,
    ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SLLI_I, SRLI_I, SRAI_I,
    LB_I, LH_I, LW_I, LBU_I, LHU_I,
    SB_I, SH_I, SW_I,
    BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I,
    JAL_I, JALR_I, LUI_I, AUIPC_I
  } op_t;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic imm_t fmt_imm(input fmt_t f);
    case (f)
      FMT_I:   return IMM_I;
      FMT_S:   return IMM_S;
      FMT_B:   return IMM_B;
      FMT_U:   return IMM_U;
      FMT_J:   return IMM_J;
      default: return IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm_extract(input logic [31:0] i, input imm_t t);
    case (t)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/de_stage_sb_scoreboard.sv
// Per-register pending-write counters; counts instructions issued to AGEX
// that have not yet written back.
module de_scoreboard #(
  parameter  int NREGS        = 32,
  parameter  int MAX_INFLIGHT = 3,
  localparam int REGNOBITS    = $clog2(NREGS),
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic [REGNOBITS-1:0] inc_reg,
  input  logic                 dec,
  input  logic [REGNOBITS-1:0] dec_reg,
  input  logic [REGNOBITS-1:0] q_rs1,
  input  logic [REGNOBITS-1:0] q_rs2,
  input  logic [REGNOBITS-1:0] q_rd,
  output logic                 busy_rs1,
  output logic                 busy_rs2,
  output logic                 one_rs1,
  output logic                 one_rs2,
  output logic                 full_rd,
  output logic                 afull_rd
);

  logic [CW-1:0] cnt [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        // simultaneous inc/dec of one register cancel; both ends saturate
        if (inc && inc_reg == REGNOBITS'(i) && !(dec && dec_reg == REGNOBITS'(i))) begin
          if (cnt[i] != CW'(MAX_INFLIGHT)) cnt[i] <= cnt[i] + 1'b1;
        end else if (dec && dec_reg == REGNOBITS'(i) && !(inc && inc_reg == REGNOBITS'(i))) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  assign busy_rs1 = (cnt[q_rs1] != '0);
  assign busy_rs2 = (cnt[q_rs2] != '0);
  assign one_rs1  = (cnt[q_rs1] == CW'(1));
  assign one_rs2  = (cnt[q_rs2] == CW'(1));
  assign full_rd  = (cnt[q_rd] == CW'(MAX_INFLIGHT));
  assign afull_rd = (cnt[q_rd] == CW'(MAX_INFLIGHT - 1));

endmodule

// File: rtl/de_stage_sb.sv
// Scoreboarded RV32I decode stage with valid/ready handshakes and flush.
// Optional same-cycle WB-to-operand bypass: define DE_WB_BYPASS_EN.
module de_stage_sb
  import de_pkg::*;
#(
  parameter  int DBITS        = 32,
  parameter  int NREGS        = 32,
  parameter  int MAX_INFLIGHT = 3,
  parameter  int INSTBITS     = 32,
  localparam int REGNOBITS    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fe_valid,
  input  logic [INSTBITS-1:0]  fe_inst,
  input  logic [DBITS-1:0]     fe_pc,
  output logic                 fe_ready,
  input  logic                 flush,
  output logic                 de_valid,
  output logic [IOPBITS-1:0]   de_op,
  output logic [DBITS-1:0]     de_pc,
  output logic [DBITS-1:0]     de_imm,
  output logic [DBITS-1:0]     de_rs1_val,
  output logic [DBITS-1:0]     de_rs2_val,
  output logic [REGNOBITS-1:0] de_rd,
  output logic                 de_wr_reg,
  input  logic                 agex_ready,
  input  logic                 wb_wr,
  input  logic [REGNOBITS-1:0] wb_regno,
  input  logic [DBITS-1:0]     wb_val
);

`ifdef DE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [6:0]           opc, f7;
  logic [2:0]           f3;
  logic [REGNOBITS-1:0] rs1, rs2, rd;
  op_t                  op;
  fmt_t                 fmt;
  logic [DBITS-1:0]     imm;
  logic                 use1, use2, wr;

  assign opc = fe_inst[6:0];
  assign f3  = fe_inst[14:12];
  assign f7  = fe_inst[31:25];
  assign rd  = REGNOBITS'(fe_inst[11:7]);
  assign rs1 = REGNOBITS'(fe_inst[19:15]);
  assign rs2 = REGNOBITS'(fe_inst[24:20]);

  always_comb begin
    op  = INVALID_I;
    fmt = FMT_NONE;
    case (opc)
      OPC_OP: begin
        fmt = FMT_R;
        case ({f7, f3})
          {F7_BASE, F3_ADD}:  op = ADD_I;
          {F7_ALT,  F3_ADD}:  op = SUB_I;
          {F7_BASE, F3_AND}:  op = AND_I;
          {F7_BASE, F3_OR}:   op = OR_I;
          {F7_BASE, F3_XOR}:  op = XOR_I;
          {F7_BASE, F3_SLT}:  op = SLT_I;
          {F7_BASE, F3_SLTU}: op = SLTU_I;
          {F7_BASE, F3_SLL}:  op = SLL_I;
          {F7_BASE, F3_SRL}:  op = SRL_I;
          {F7_ALT,  F3_SRL}:  op = SRA_I;
          default:            op = INVALID_I;
        endcase
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        case (f3)
          F3_ADD:  op = ADDI_I;
          F3_AND:  op = ANDI_I;
          F3_OR:   op = ORI_I;
          F3_XOR:  op = XORI_I;
          F3_SLT:  op = SLTI_I;
          F3_SLTU: op = SLTIU_I;
          F3_SLL:  op = (f7 == F7_BASE) ? SLLI_I : INVALID_I;
          default: op = (f7 == F7_BASE) ? SRLI_I : (f7 == F7_ALT) ? SRAI_I : INVALID_I;
        endcase
      end
      OPC_LOAD: begin
        fmt = FMT_I;
        case (f3)
          F3_B:    op = LB_I;
          F3_H:    op = LH_I;
          F3_W:    op = LW_I;
          F3_BU:   op = LBU_I;
          F3_HU:   op = LHU_I;
          default: op = INVALID_I;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S;
        case (f3)
          F3_B:    op = SB_I;
          F3_H:    op = SH_I;
          F3_W:    op = SW_I;
          default: op = INVALID_I;
        endcase
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        case (f3)
          F3_BEQ:  op = BEQ_I;
          F3_BNE:  op = BNE_I;
          F3_BLT:  op = BLT_I;
          F3_BGE:  op = BGE_I;
          F3_BLTU: op = BLTU_I;
          F3_BGEU: op = BGEU_I;
          default: op = INVALID_I;
        endcase
      end
      OPC_JAL: begin
        fmt = FMT_J;
        op  = JAL_I;
      end
      OPC_JALR: begin
        fmt = FMT_I;
        op  = (f3 == 3'b000) ? JALR_I : INVALID_I;
      end
      OPC_LUI: begin
        fmt = FMT_U;
        op  = LUI_I;
      end
      OPC_AUIPC: begin
        fmt = FMT_U;
        op  = AUIPC_I;
      end
      default: begin
        fmt = FMT_NONE;
        op  = INVALID_I;
      end
    endcase
    // unknown encodings issue as a NOP that reads and writes nothing
    if (op == INVALID_I) fmt = FMT_NONE;
  end

  assign imm  = DBITS'($signed(imm_extract(fe_inst[31:0], fmt_imm(fmt))));
  assign use1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign use2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  assign wr   = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J)) && (rd != '0);

  logic busy1, busy2, one1, one2, full_rd, afull_rd;
  logic issue, wb_en;

  assign issue = de_valid && agex_ready && de_wr_reg && !flush;
  assign wb_en = wb_wr && (wb_regno != '0);

  de_scoreboard #(
    .NREGS        (NREGS),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .inc      (issue),
    .inc_reg  (de_rd),
    .dec      (wb_en),
    .dec_reg  (wb_regno),
    .q_rs1    (rs1),
    .q_rs2    (rs2),
    .q_rd     (rd),
    .busy_rs1 (busy1),
    .busy_rs2 (busy2),
    .one_rs1  (one1),
    .one_rs2  (one2),
    .full_rd  (full_rd),
    .afull_rd (afull_rd)
  );

  logic lm1, lm2, lmd, byp1, byp2, haz1, haz2, structural;

  assign lm1  = de_valid && de_wr_reg && (de_rd == rs1);
  assign lm2  = de_valid && de_wr_reg && (de_rd == rs2);
  assign lmd  = de_valid && de_wr_reg && (de_rd == rd);
  assign byp1 = BYPASS && one1 && wb_wr && (wb_regno == rs1) && !lm1;
  assign byp2 = BYPASS && one2 && wb_wr && (wb_regno == rs2) && !lm2;
  assign haz1 = use1 && (rs1 != '0) && ((busy1 && !byp1) || lm1);
  assign haz2 = use2 && (rs2 != '0) && ((busy2 && !byp2) || lm2);
  // a same-rd writer still in the latch will claim a slot when it issues
  assign structural = wr && (full_rd || (afull_rd && lmd));

  assign fe_ready = !haz1 && !haz2 && !structural && (!de_valid || agex_ready) && !flush;

  logic [DBITS-1:0] regs [NREGS];
  logic [DBITS-1:0] rv1, rv2;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_regno] <= wb_val;
    end
  end

  assign rv1 = (rs1 == '0) ? '0 : byp1 ? wb_val : regs[rs1];
  assign rv2 = (rs2 == '0) ? '0 : byp2 ? wb_val : regs[rs2];

  always_ff @(posedge clk) begin
    if (reset) begin
      de_valid   <= 1'b0;
      de_op      <= '0;
      de_pc      <= '0;
      de_imm     <= '0;
      de_rs1_val <= '0;
      de_rs2_val <= '0;
      de_rd      <= '0;
      de_wr_reg  <= 1'b0;
    end else if (flush) begin
      de_valid <= 1'b0;
    end else if (!de_valid || agex_ready) begin
      de_valid <= fe_valid && fe_ready;
      if (fe_valid && fe_ready) begin
        de_op      <= op;
        de_pc      <= fe_pc;
        de_imm     <= imm;
        de_rs1_val <= rv1;
        de_rs2_val <= rv2;
        de_rd      <= rd;
        de_wr_reg  <= wr;
      end
    end
  end

endmodule
